// File: rtl/axil_simplebus_bridge_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces for the AXI-Lite to Simplebus bridge.
//
// axi_lite_if  : 32-bit AXI-Lite channel bundle (AW, W, B, AR, R).
//   master modport drives requests and response readies (interconnect side).
//   slave  modport drives channel readies and responses (bridge side).
// simplebus_if : single-strobe peripheral bus.
//   master modport drives address, write data and the write/read strobes.
//   slave  modport drives sb_ready, sb_read_valid and sb_read_data.
// -----------------------------------------------------------------------------
interface axi_lite_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

interface simplebus_if;
    logic [31:0] sb_address;
    logic [31:0] sb_write_data;
    logic        sb_write_strobe;
    logic        sb_read_strobe;
    logic        sb_ready;
    logic        sb_read_valid;
    logic [31:0] sb_read_data;

    modport master (
        output sb_address, sb_write_data, sb_write_strobe, sb_read_strobe,
        input  sb_ready, sb_read_valid, sb_read_data
    );

    modport slave (
        input  sb_address, sb_write_data, sb_write_strobe, sb_read_strobe,
        output sb_ready, sb_read_valid, sb_read_data
    );
endinterface

// File: rtl/axil_simplebus_bridge.sv
// -----------------------------------------------------------------------------
// axil_simplebus_bridge
//
// AXI-Lite slave that replays each accepted transaction as a single Simplebus
// strobe. One transaction is in flight at a time; AW, W and AR each have a
// single capture slot, so the next request can be accepted while the current
// one is still being serviced.
//
// Ports:
//   clock  : system clock, rising edge.
//   reset  : asynchronous active-low reset.
//   axi_in : AXI-Lite target port (axi_lite_if.slave).
//   sb_out : Simplebus initiator port (simplebus_if.master).
//
// Parameters:
//   BASE_ADDRESS : subtracted (mod 2^32) from AXI addresses before driving sb_address.
//   READ_TIMEOUT : cycles allowed for sb_read_valid after a read strobe (>= 2).
// -----------------------------------------------------------------------------
module axil_simplebus_bridge #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned READ_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    axi_lite_if.slave   axi_in,
    simplebus_if.master sb_out
);

    localparam int unsigned      CNT_W    = $clog2(READ_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_STROBE = 3'd1,
        WR_RESP   = 3'd2,
        RD_STROBE = 3'd3,
        RD_WAIT   = 3'd4,
        RD_RESP   = 3'd5
    } state_t;

    state_t           state_r;
    logic             prio_r;            // 0: read wins a tie, 1: write wins
    logic [CNT_W-1:0] cnt_r;

    logic             aw_flag_r;
    logic             w_flag_r;
    logic             ar_flag_r;
    logic [31:0]      awaddr_r;
    logic [31:0]      wdata_r;
    logic [31:0]      araddr_r;
    logic             awready_r;
    logic             wready_r;
    logic             arready_r;

    logic             bvalid_r;
    logic [1:0]       bresp_r;
    logic             rvalid_r;
    logic [1:0]       rresp_r;
    logic [31:0]      rdata_r;
    logic [31:0]      sb_address_r;
    logic [31:0]      sb_write_data_r;
    logic             sb_write_strobe_r;
    logic             sb_read_strobe_r;

    logic             aw_hs_s;
    logic             w_hs_s;
    logic             ar_hs_s;
    logic             b_hs_s;
    logic             r_hs_s;
    logic             aw_flag_nxt_s;
    logic             w_flag_nxt_s;
    logic             ar_flag_nxt_s;
    logic             wr_pend_s;
    logic             rd_pend_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             timeout_s;

    // Byte strobes are not supported; every write is a full word.
    logic             unused_wstrb_s;
    assign unused_wstrb_s = ^axi_in.wstrb;

    // Handshake detection, next capture-flag values and timeout compare.
    always_comb begin
        aw_hs_s = axi_in.awvalid & awready_r;
        w_hs_s  = axi_in.wvalid  & wready_r;
        ar_hs_s = axi_in.arvalid & arready_r;
        b_hs_s  = bvalid_r & axi_in.bready;
        r_hs_s  = rvalid_r & axi_in.rready;

        // A slot cannot be captured and released in the same cycle: its ready
        // is low for as long as the flag is set.
        if (b_hs_s) begin
            aw_flag_nxt_s = 1'b0;
            w_flag_nxt_s  = 1'b0;
        end else begin
            aw_flag_nxt_s = aw_flag_r | aw_hs_s;
            w_flag_nxt_s  = w_flag_r  | w_hs_s;
        end

        if (r_hs_s) begin
            ar_flag_nxt_s = 1'b0;
        end else begin
            ar_flag_nxt_s = ar_flag_r | ar_hs_s;
        end

        wr_pend_s = aw_flag_r & w_flag_r;
        rd_pend_s = ar_flag_r;

        // The compare looks at the incremented value so that the error
        // response lands READ_TIMEOUT cycles after the read strobe.
        cnt_inc_s = cnt_r + CNT_W'(1);
        timeout_s = (cnt_inc_s == CNT_LAST);
    end

    // Channel capture slots and their registered readies.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aw_flag_r <= 1'b0;
            w_flag_r  <= 1'b0;
            ar_flag_r <= 1'b0;
            awaddr_r  <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            araddr_r  <= 32'h0000_0000;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            arready_r <= 1'b0;
        end else begin
            aw_flag_r <= aw_flag_nxt_s;
            w_flag_r  <= w_flag_nxt_s;
            ar_flag_r <= ar_flag_nxt_s;
            awready_r <= ~aw_flag_nxt_s;
            wready_r  <= ~w_flag_nxt_s;
            arready_r <= ~ar_flag_nxt_s;
            if (aw_hs_s) begin
                awaddr_r <= axi_in.awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= axi_in.wdata;
            end
            if (ar_hs_s) begin
                araddr_r <= axi_in.araddr;
            end
        end
    end

    // Transaction sequencer with registered bus and response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r           <= IDLE;
            prio_r            <= 1'b0;
            cnt_r             <= '0;
            bvalid_r          <= 1'b0;
            bresp_r           <= 2'b00;
            rvalid_r          <= 1'b0;
            rresp_r           <= 2'b00;
            rdata_r           <= 32'h0000_0000;
            sb_address_r      <= 32'h0000_0000;
            sb_write_data_r   <= 32'h0000_0000;
            sb_write_strobe_r <= 1'b0;
            sb_read_strobe_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sb_out.sb_ready && wr_pend_s && (!rd_pend_s || prio_r)) begin
                        sb_address_r      <= awaddr_r - BASE_ADDRESS;
                        sb_write_data_r   <= wdata_r;
                        sb_write_strobe_r <= 1'b1;
                        state_r           <= WR_STROBE;
                        if (rd_pend_s) begin
                            prio_r <= 1'b0;
                        end
                    end else if (sb_out.sb_ready && rd_pend_s) begin
                        sb_address_r     <= araddr_r - BASE_ADDRESS;
                        sb_read_strobe_r <= 1'b1;
                        state_r          <= RD_STROBE;
                        if (wr_pend_s) begin
                            prio_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WR_STROBE: begin
                    sb_write_strobe_r <= 1'b0;
                    sb_write_data_r   <= 32'h0000_0000;
                    bvalid_r          <= 1'b1;
                    bresp_r           <= 2'b00;
                    state_r           <= WR_RESP;
                end
                WR_RESP: begin
                    if (axi_in.bready) begin
                        bvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= WR_RESP;
                    end
                end
                RD_STROBE: begin
                    sb_read_strobe_r <= 1'b0;
                    cnt_r            <= '0;
                    state_r          <= RD_WAIT;
                end
                RD_WAIT: begin
                    cnt_r <= cnt_inc_s;
                    if (sb_out.sb_read_valid) begin
                        rdata_r  <= sb_out.sb_read_data;
                        rresp_r  <= 2'b00;
                        rvalid_r <= 1'b1;
                        state_r  <= RD_RESP;
                    end else if (timeout_s) begin
                        rdata_r  <= 32'h0000_0000;
                        rresp_r  <= 2'b10;
                        rvalid_r <= 1'b1;
                        state_r  <= RD_RESP;
                    end else begin
                        state_r <= RD_WAIT;
                    end
                end
                RD_RESP: begin
                    if (axi_in.rready) begin
                        rvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= RD_RESP;
                    end
                end
                default: begin
                    sb_write_strobe_r <= 1'b0;
                    sb_read_strobe_r  <= 1'b0;
                    bvalid_r          <= 1'b0;
                    rvalid_r          <= 1'b0;
                    state_r           <= IDLE;
                end
            endcase
        end
    end

    assign axi_in.awready        = awready_r;
    assign axi_in.wready         = wready_r;
    assign axi_in.arready        = arready_r;
    assign axi_in.bvalid         = bvalid_r;
    assign axi_in.bresp          = bresp_r;
    assign axi_in.rvalid         = rvalid_r;
    assign axi_in.rresp          = rresp_r;
    assign axi_in.rdata          = rdata_r;
    assign sb_out.sb_address      = sb_address_r;
    assign sb_out.sb_write_data   = sb_write_data_r;
    assign sb_out.sb_write_strobe = sb_write_strobe_r;
    assign sb_out.sb_read_strobe  = sb_read_strobe_r;

endmodule

// File: tb/tb_axil_simplebus_bridge.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axil_simplebus_bridge (BASE_ADDRESS=0x43C0_0000,
// READ_TIMEOUT=16). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axil_simplebus_bridge;

    logic clk;
    logic rst_n;

    axi_lite_if  axi ();
    simplebus_if sb ();

    axil_simplebus_bridge #(
        .BASE_ADDRESS (32'h43C0_0000),
        .READ_TIMEOUT (16)
    ) dut (
        .clock  (clk),
        .reset  (rst_n),
        .axi_in (axi),
        .sb_out (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Simplebus slave model controls (written by the main sequence only).
    int          rd_delay = 0;          // 0 = never answers
    logic [31:0] rd_data  = 32'h0;

    // Strobe monitor results (written by the monitor only).
    int          wr_strobes = 0;
    int          rd_strobes = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    logic [31:0] last_rd_addr = 32'h0;
    int          last_wr_cyc = 0;
    int          last_rd_cyc = 0;
    logic        order_q[$];            // 1 = write strobe, 0 = read strobe

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] sdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Simplebus slave: answers a read strobe rd_delay cycles later.
    initial begin
        int pend;
        pend = 0;
        sb.sb_read_valid = 1'b0;
        sb.sb_read_data  = 32'h0;
        forever begin
            @(negedge clk);
            sb.sb_read_valid = 1'b0;
            sb.sb_read_data  = 32'h0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sb.sb_read_valid = 1'b1;
                    sb.sb_read_data  = rd_data;
                end
            end
            if (sb.sb_read_strobe === 1'b1 && rd_delay > 0) pend = rd_delay;
        end
    end

    // Strobe monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.sb_write_strobe === 1'b1) begin
                wr_strobes++;
                last_wr_addr = sb.sb_address;
                last_wr_data = sb.sb_write_data;
                last_wr_cyc  = cyc;
                order_q.push_back(1'b1);
            end
            if (sb.sb_read_strobe === 1'b1) begin
                rd_strobes++;
                last_rd_addr = sb.sb_address;
                last_rd_cyc  = cyc;
                order_q.push_back(1'b0);
            end
        end
    end

    // Present the selected requests and hold each until its handshake.
    task automatic send(input logic aw_en, input logic w_en, input logic ar_en,
                        input logic [31:0] aw_a, input logic [31:0] w_d, input logic [31:0] ar_a);
        logic aw_go, w_go, ar_go;
        int n;
        n = 0;
        axi.awvalid = aw_en; axi.awaddr = aw_a;
        axi.wvalid  = w_en;  axi.wdata  = w_d;
        axi.arvalid = ar_en; axi.araddr = ar_a;
        while ((axi.awvalid || axi.wvalid || axi.arvalid) && n < 50) begin
            aw_go = axi.awvalid & axi.awready;
            w_go  = axi.wvalid  & axi.wready;
            ar_go = axi.arvalid & axi.arready;
            @(negedge clk);
            n++;
            if (aw_go) axi.awvalid = 1'b0;
            if (w_go)  axi.wvalid  = 1'b0;
            if (ar_go) axi.arvalid = 1'b0;
        end
        checkb("req_accepted", axi.awvalid | axi.wvalid | axi.arvalid, 1'b0);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    endtask

    task automatic wait_b(input int hold, output logic [1:0] resp, output int at_cyc);
        int n;
        n = 0;
        while (axi.bvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checkb("bvalid_seen", axi.bvalid, 1'b1);
        at_cyc = cyc;
        resp   = axi.bresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkb("bvalid_hold", axi.bvalid, 1'b1);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        checkb("bvalid_drop", axi.bvalid, 1'b0);
    endtask

    task automatic wait_r(input int hold, output logic [31:0] data, output logic [1:0] resp,
                          output int at_cyc);
        int n;
        n = 0;
        while (axi.rvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checkb("rvalid_seen", axi.rvalid, 1'b1);
        at_cyc = cyc;
        data   = axi.rdata;
        resp   = axi.rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkb("rvalid_hold", axi.rvalid, 1'b1);
            check("rdata_hold", axi.rdata, data);
        end
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        checkb("rvalid_drop", axi.rvalid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          at, base_w, base_r, ord_base, s0, rd_left, wr_left, n;

        vecs[0] = '{1'b1, 32'h43C0_0010, 32'hDEAD_BEEF, 0,  32'h0,         32'h0000_0010, 32'hDEAD_BEEF, 2'd0, 1};
        vecs[1] = '{1'b0, 32'h43C0_0004, 32'h0,         2,  32'h0000_1234, 32'h0000_0004, 32'h0000_1234, 2'd0, 3};
        vecs[2] = '{1'b1, 32'h43C0_0FFC, 32'h0000_0001, 0,  32'h0,         32'h0000_0FFC, 32'h0000_0001, 2'd0, 1};
        vecs[3] = '{1'b1, 32'h0000_0008, 32'h8000_0000, 0,  32'h0,         32'hBC40_0008, 32'h8000_0000, 2'd0, 1};
        vecs[4] = '{1'b0, 32'h43C0_0100, 32'h0,         1,  32'hA5A5_5A5A, 32'h0000_0100, 32'hA5A5_5A5A, 2'd0, 2};
        vecs[5] = '{1'b0, 32'h43C0_0200, 32'h0,         15, 32'hCAFE_F00D, 32'h0000_0200, 32'hCAFE_F00D, 2'd0, 16};
        vecs[6] = '{1'b0, 32'h43C0_0300, 32'h0,         0,  32'hFFFF_FFFF, 32'h0000_0300, 32'h0000_0000, 2'd2, 16};
        vecs[7] = '{1'b1, 32'h43C0_0020, 32'h1111_2222, 0,  32'h0,         32'h0000_0020, 32'h1111_2222, 2'd0, 1};
        vecs[8] = '{1'b0, 32'h43C0_0400, 32'h0,         16, 32'h7777_7777, 32'h0000_0400, 32'h0000_0000, 2'd2, 16};
        vecs[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         3,  32'h0BAD_F00D, 32'hBC3F_FFFC, 32'h0BAD_F00D, 2'd0, 4};

        rst_n = 1'b0;
        axi.awvalid = 1'b0; axi.awaddr = 32'h0; axi.wvalid = 1'b0; axi.wdata = 32'h0;
        axi.wstrb = 4'hF; axi.bready = 1'b0; axi.arvalid = 1'b0; axi.araddr = 32'h0;
        axi.rready = 1'b0;
        sb.sb_ready = 1'b1;

        // Reset state and ready release.
        repeat (2) @(negedge clk);
        checkb("rst_awready", axi.awready, 1'b0);
        checkb("rst_arready", axi.arready, 1'b0);
        checkb("rst_bvalid", axi.bvalid, 1'b0);
        checkb("rst_rvalid", axi.rvalid, 1'b0);
        checkb("rst_wstrobe", sb.sb_write_strobe, 1'b0);
        check("rst_sb_addr", sb.sb_address, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkb("rel_awready", axi.awready, 1'b1);
        checkb("rel_wready", axi.wready, 1'b1);
        checkb("rel_arready", axi.arready, 1'b1);

        // AW and W together: exact strobe and BVALID timing, BREADY held off.
        send(1'b1, 1'b1, 1'b0, 32'h43C0_0010, 32'hDEAD_BEEF, 32'h0);
        checkb("t1_no_early_strobe", sb.sb_write_strobe, 1'b0);
        checkb("t1_awready_low", axi.awready, 1'b0);
        @(negedge clk);
        checkb("t1_strobe", sb.sb_write_strobe, 1'b1);
        check("t1_addr", sb.sb_address, 32'h0000_0010);
        check("t1_data", sb.sb_write_data, 32'hDEAD_BEEF);
        checkb("t1_no_bvalid_yet", axi.bvalid, 1'b0);
        @(negedge clk);
        checkb("t1_strobe_end", sb.sb_write_strobe, 1'b0);
        check("t1_wdata_cleared", sb.sb_write_data, 32'h0);
        checkb("t1_bvalid", axi.bvalid, 1'b1);
        wait_b(3, resp, at);
        check("t1_bresp", 32'(resp), 32'd0);
        checkb("t1_awready_back", axi.awready, 1'b1);

        // W five cycles ahead of AW.
        base_w = wr_strobes;
        send(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        checkb("wfirst_wready_low", axi.wready, 1'b0);
        repeat (5) @(negedge clk);
        check("wfirst_no_strobe", 32'(wr_strobes - base_w), 32'd0);
        send(1'b1, 1'b0, 1'b0, 32'h43C0_0010, 32'h0, 32'h0);
        wait_b(0, resp, at);
        check("wfirst_strobes", 32'(wr_strobes - base_w), 32'd1);
        check("wfirst_addr", last_wr_addr, 32'h0000_0010);
        check("wfirst_data", last_wr_data, 32'hDEAD_BEEF);

        // Read with RREADY held low for 4 cycles.
        rd_delay = 2; rd_data = 32'h0000_1234;
        send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h43C0_0004);
        checkb("rd_no_early_strobe", sb.sb_read_strobe, 1'b0);
        @(negedge clk);
        checkb("rd_strobe", sb.sb_read_strobe, 1'b1);
        check("rd_addr", sb.sb_address, 32'h0000_0004);
        wait_r(4, data, resp, at);
        check("rd_data", data, 32'h0000_1234);
        check("rd_resp", 32'(resp), 32'd0);

        // Table-driven transactions.
        for (int i = 0; i < 10; i++) begin
            base_w = wr_strobes;
            base_r = rd_strobes;
            if (vecs[i].is_wr) begin
                send(1'b1, 1'b1, 1'b0, vecs[i].addr, vecs[i].wdata, 32'h0);
                wait_b(0, resp, at);
                check($sformatf("v%0d_wr_count", i), 32'(wr_strobes - base_w), 32'd1);
                check($sformatf("v%0d_rd_count", i), 32'(rd_strobes - base_r), 32'd0);
                check($sformatf("v%0d_addr", i), last_wr_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_data", i), last_wr_data, vecs[i].exp_data);
                check($sformatf("v%0d_resp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_lat", i), 32'(at - last_wr_cyc), 32'(vecs[i].exp_lat));
                check($sformatf("v%0d_wdata_idle", i), sb.sb_write_data, 32'h0);
            end else begin
                rd_delay = vecs[i].delay;
                rd_data  = vecs[i].sdata;
                send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, vecs[i].addr);
                wait_r(0, data, resp, at);
                check($sformatf("v%0d_rd_count", i), 32'(rd_strobes - base_r), 32'd1);
                check($sformatf("v%0d_wr_count", i), 32'(wr_strobes - base_w), 32'd0);
                check($sformatf("v%0d_addr", i), last_rd_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
                check($sformatf("v%0d_resp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_lat", i), 32'(at - last_rd_cyc), 32'(vecs[i].exp_lat));
            end
            repeat (3) @(negedge clk);
            checkb($sformatf("v%0d_no_stray_rvalid", i), axi.rvalid, 1'b0);
        end

        // Read and write both pending, sb_ready low for 10 cycles first.
        rd_delay = 1; rd_data = 32'h5555_0000;
        sb.sb_ready = 1'b0;
        ord_base = order_q.size();
        s0 = wr_strobes + rd_strobes;
        send(1'b1, 1'b1, 1'b1, 32'h43C0_0040, 32'h0000_0040, 32'h43C0_0044);
        repeat (10) @(negedge clk);
        check("busy_no_strobe", 32'(wr_strobes + rd_strobes - s0), 32'd0);
        sb.sb_ready = 1'b1;
        rd_left = 3; wr_left = 3;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!(axi.rvalid === 1'b1 || axi.bvalid === 1'b1) && n < 200) begin
                @(negedge clk); n++;
            end
            checkb("prio_resp_seen", axi.rvalid | axi.bvalid, 1'b1);
            if (axi.rvalid === 1'b1) begin
                axi.rready = 1'b1; @(negedge clk); axi.rready = 1'b0;
                rd_left--;
                if (rd_left > 0) send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h43C0_0044);
            end else if (axi.bvalid === 1'b1) begin
                axi.bready = 1'b1; @(negedge clk); axi.bready = 1'b0;
                wr_left--;
                if (wr_left > 0) send(1'b1, 1'b1, 1'b0, 32'h43C0_0040, 32'h0000_0040, 32'h0);
            end
        end
        check("order_len", 32'(order_q.size() - ord_base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (ord_base + i < order_q.size())
                checkb($sformatf("order_%0d", i), order_q[ord_base + i], (i % 2) == 1);
        end

        // Reset while waiting on an unresponsive read.
        rd_delay = 0;
        send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h43C0_0008);
        repeat (3) @(negedge clk);
        checkb("pre_rst_no_rvalid", axi.rvalid, 1'b0);
        rst_n = 1'b0;
        #1;
        checkb("arst_awready", axi.awready, 1'b0);
        checkb("arst_wready", axi.wready, 1'b0);
        checkb("arst_arready", axi.arready, 1'b0);
        checkb("arst_bvalid", axi.bvalid, 1'b0);
        checkb("arst_rvalid", axi.rvalid, 1'b0);
        check("arst_bresp", 32'(axi.bresp), 32'd0);
        check("arst_rresp", 32'(axi.rresp), 32'd0);
        check("arst_rdata", axi.rdata, 32'h0);
        check("arst_sb_addr", sb.sb_address, 32'h0);
        check("arst_sb_wdata", sb.sb_write_data, 32'h0);
        checkb("arst_wstrobe", sb.sb_write_strobe, 1'b0);
        checkb("arst_rstrobe", sb.sb_read_strobe, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkb("post_rst_arready", axi.arready, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (axi.rvalid !== 1'b0) n++;
            @(negedge clk);
        end
        check("post_rst_no_rvalid", 32'(n), 32'd0);
        base_w = wr_strobes;
        send(1'b1, 1'b1, 1'b0, 32'h43C0_0030, 32'h0F0F_0F0F, 32'h0);
        wait_b(0, resp, at);
        check("post_rst_wr_count", 32'(wr_strobes - base_w), 32'd1);
        check("post_rst_wr_addr", last_wr_addr, 32'h0000_0030);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_simplebus_bridge.md
Name: axil_simplebus_bridge

Overview:
- AXI-Lite slave to Simplebus master bridge: accepts AXI-Lite read/write transactions from the processing-system interconnect and replays them as single Simplebus strobes towards the peripheral register banks.
- Sits directly upstream of every Simplebus slave and is the only Simplebus master on its segment.
- Handles one outstanding transaction at a time; write address and write data may arrive in either order.

Parameters:
BASE_ADDRESS, 32'h0, subtracted from AXI addresses before they are driven on sb_address.
READ_TIMEOUT, 16, cycles to wait for sb_read_valid after the read strobe before erroring; minimum 2.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
axi_in  slave modport  axi_lite interface  AXI-Lite target port.
sb_out  master modport  Simplebus interface  Simplebus initiator port.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, sb_address, sb_write_data, sb_write_strobe, sb_read_strobe.
  - Capture flags are cleared and the state is IDLE.
  - Reset mid-transaction abandons the transaction silently; no response is issued.
- Channel capture:
  - AWREADY, WREADY and ARREADY are registered.
  - Each ready is 1 while its capture register is empty, from the first cycle after reset release.
  - A handshake (VALID&READY) latches AWADDR, WDATA or ARADDR and sets the matching flag; that ready drops the next cycle.
  - Flags clear when the owning transaction issues its response handshake.
  - WSTRB is ignored; all writes are full 32-bit words.
- FSM states: IDLE, WR_STROBE, WR_RESP, RD_STROBE, RD_WAIT, RD_RESP.
- IDLE:
  - A write is pending when the aw and w flags are both set. A read is pending when the ar flag is set.
  - Transitions require sb_ready=1; otherwise stay in IDLE.
  - If only one transaction is pending, start it.
  - If both are pending, a prio register chooses the winner and then toggles. prio resets to read-first.
- WR_STROBE:
  - For exactly 1 cycle: sb_address = captured AWADDR - BASE_ADDRESS (32-bit modulo), sb_write_data = WDATA, sb_write_strobe=1.
  - Next cycle the strobe returns to 0 and sb_write_data returns to 0. Go to WR_RESP.
- WR_RESP:
  - BVALID=1, BRESP=0 (OKAY), held until BREADY.
  - On the handshake, clear the aw/w flags and return to IDLE.
- RD_STROBE:
  - For 1 cycle: sb_address = ARADDR - BASE_ADDRESS, sb_read_strobe=1.
  - Clear the timeout counter and go to RD_WAIT.
- RD_WAIT:
  - The counter increments each cycle.
  - When sb_read_valid=1: RDATA <= sb_read_data, RRESP <= 0, go to RD_RESP.
  - When the counter reaches READ_TIMEOUT-1 without sb_read_valid: RDATA <= 0, RRESP <= 2 (SLVERR), go to RD_RESP.
  - If sb_read_valid and the timeout coincide, valid wins.
- RD_RESP:
  - RVALID=1 with RDATA/RRESP stable until RREADY.
  - On the handshake, clear the ar flag, drop RVALID and return to IDLE.
- Pre-capture: new AW/W/AR beats may be captured while another transaction is in flight (single slot per channel). They are serviced after the current transaction returns to IDLE.
- Minimum latencies:
  - Write: last of AW/W handshake -> BVALID in 3 cycles (capture, IDLE, WR_STROBE).
  - Read: AR handshake -> sb_read_strobe in 2 cycles; sb_read_valid -> RVALID in 1 cycle.
- sb_read_valid outside RD_WAIT is ignored.

Test Plan:
- AW 0x43C0_0010 and W 0xDEAD_BEEF in the same cycle, BASE_ADDRESS=0x43C0_0000 -> one-cycle sb_write_strobe with sb_address=0x10 and data 0xDEADBEEF; BVALID with BRESP=0 three cycles later; held until BREADY.
- W arrives 5 cycles before AW -> WREADY drops after the W beat, no strobe until AW is captured, then an identical single strobe.
- AR 0x43C0_0004, slave returns sb_read_valid with 0x1234 two cycles after the strobe -> RDATA=0x1234, RRESP=0; RREADY held low for 4 cycles keeps RVALID and RDATA stable.
- AR to an unresponsive slave, READ_TIMEOUT=16 -> RVALID 16 cycles after the strobe with RDATA=0 and RRESP=2; bridge accepts a following write normally.
- Read and complete write both pending in IDLE, repeated 3 times -> order is read, write, read, write, read, write; sb_ready held low for 10 cycles delays the strobes with no strobe issued in that window.
- reset pulled low during RD_WAIT -> all outputs 0 immediately; after release, ARREADY=1 the next cycle and no stale RVALID appears.
